// File: rtl/btn_press_gen.sv
// Button-press stimulus generator: emits a programmable number of active-low
// presses on nbtn, each framed by contact-bounce bursts on press and release.
module btn_press_gen #(
    parameter logic [31:0] PRESS_CYCLES   = 32'd4000000,
    parameter logic [31:0] RELEASE_CYCLES = 32'd4000000,
    parameter logic [3:0]  BOUNCE_PAIRS   = 4'd3,
    parameter logic [31:0] BOUNCE_CYCLES  = 32'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] count,
    output logic       nbtn,
    output logic       busy,
    output logic       done,
    output logic [3:0] presses_sent
);

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_DN,
        HOLD,
        BOUNCE_UP,
        GAP
    } state_t;

    localparam bit          HAS_BOUNCE   = (BOUNCE_PAIRS != 4'd0);
    localparam logic [3:0]  LAST_PAIR    = BOUNCE_PAIRS - 4'd1;
    localparam logic [31:0] LAST_BOUNCE  = BOUNCE_CYCLES - 32'd1;
    localparam logic [31:0] LAST_PRESS   = PRESS_CYCLES - 32'd1;
    localparam logic [31:0] LAST_RELEASE = RELEASE_CYCLES - 32'd1;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  pair_q, pair_d;
    logic        half_q, half_d;
    logic [3:0]  target_q, target_d;
    logic        nbtn_d, busy_d, done_d;
    logic [3:0]  sent_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pair_q       <= '0;
            half_q       <= 1'b0;
            target_q     <= '0;
            nbtn         <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            presses_sent <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pair_q       <= pair_d;
            half_q       <= half_d;
            target_q     <= target_d;
            nbtn         <= nbtn_d;
            busy         <= busy_d;
            done         <= done_d;
            presses_sent <= sent_d;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the phase itself; a phase of length L therefore shows for L cycles.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 32'd1;
        pair_d   = pair_q;
        half_d   = half_q;
        target_d = target_q;
        busy_d   = busy;
        done_d   = 1'b0;
        sent_d   = presses_sent;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    sent_d = '0;
                    if (count != 4'd0) begin
                        target_d = count;
                        busy_d   = 1'b1;
                        pair_d   = '0;
                        half_d   = 1'b0;
                        state_d  = HAS_BOUNCE ? BOUNCE_DN : HOLD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            BOUNCE_DN, BOUNCE_UP: begin
                if (cnt_q == LAST_BOUNCE) begin
                    cnt_d  = '0;
                    half_d = ~half_q;
                    if (half_q) begin
                        if (pair_q == LAST_PAIR) begin
                            pair_d  = '0;
                            state_d = (state_q == BOUNCE_DN) ? HOLD : GAP;
                        end else begin
                            pair_d = pair_q + 4'd1;
                        end
                    end
                end
            end

            HOLD: begin
                if (cnt_q == LAST_PRESS) begin
                    cnt_d   = '0;
                    sent_d  = presses_sent + 4'd1;
                    half_d  = 1'b0;
                    state_d = HAS_BOUNCE ? BOUNCE_UP : GAP;
                end
            end

            GAP: begin
                if (cnt_q == LAST_RELEASE) begin
                    cnt_d  = '0;
                    half_d = 1'b0;
                    if (presses_sent == target_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = HAS_BOUNCE ? BOUNCE_DN : HOLD;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        unique case (state_d)
            BOUNCE_DN: nbtn_d = half_d;
            HOLD:      nbtn_d = 1'b0;
            BOUNCE_UP: nbtn_d = ~half_d;
            default:   nbtn_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_btn_press_gen.sv
// Directed bench for btn_press_gen: per-cycle comparison of every output
// against a waveform model built from the press-period arithmetic.
module tb_btn_press_gen;

    localparam int PC = 8;
    localparam int RC = 6;
    localparam int BC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [3:0] count_a = '0, count_b = '0;
    logic       nbtn_a, busy_a, done_a, nbtn_b, busy_b, done_b;
    logic [3:0] sent_a, sent_b;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    btn_press_gen #(
        .PRESS_CYCLES(32'd8), .RELEASE_CYCLES(32'd6),
        .BOUNCE_PAIRS(4'd2), .BOUNCE_CYCLES(32'd3)
    ) dut (
        .clk(clk), .rst(rst), .start(start_a), .count(count_a),
        .nbtn(nbtn_a), .busy(busy_a), .done(done_a), .presses_sent(sent_a)
    );

    btn_press_gen #(
        .PRESS_CYCLES(32'd8), .RELEASE_CYCLES(32'd6),
        .BOUNCE_PAIRS(4'd0), .BOUNCE_CYCLES(32'd3)
    ) dut_nb (
        .clk(clk), .rst(rst), .start(start_b), .count(count_b),
        .nbtn(nbtn_b), .busy(busy_b), .done(done_b), .presses_sent(sent_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit sel, input logic s);
        if (sel) start_b = s;
        else     start_a = s;
    endtask

    task automatic set_count(input bit sel, input logic [3:0] c);
        if (sel) count_b = c;
        else     count_a = c;
    endtask

    // Start a sequence of n presses (unless armed: start already driven) and
    // check len cycles after the accepting edge. inj: offset of an ignored
    // start with count=5; nxt>=0: arm a back-to-back start on the last cycle.
    task automatic run_seq(input string name, input bit sel, input int n, input int len,
                           input int inj, input int nxt, input bit armed);
        int bp, db, per, k, p, sent;
        bit e_nbtn, e_busy, e_done;
        bp  = sel ? 0 : 2;
        db  = 2 * bp * BC;
        per = 2 * db + PC + RC;
        if (!armed) begin
            @(negedge clk);
            set_start(sel, 1'b1);
            set_count(sel, 4'(n));
        end
        for (int unsigned i = 1; i <= int'(len); i++) begin
            @(negedge clk);
            if (int'(i) <= n * per) begin
                k      = (int'(i) - 1) / per;
                p      = (int'(i) - 1) % per;
                e_busy = 1'b1;
                e_done = 1'b0;
                if (p < db)                e_nbtn = ((p / BC) % 2) != 0;
                else if (p < db + PC)      e_nbtn = 1'b0;
                else if (p < 2 * db + PC)  e_nbtn = (((p - db - PC) / BC) % 2) == 0;
                else                       e_nbtn = 1'b1;
                sent = k + ((p >= db + PC) ? 1 : 0);
            end else begin
                e_busy = 1'b0;
                e_done = (int'(i) == n * per + 1);
                e_nbtn = 1'b1;
                sent   = n;
            end
            check($sformatf("%s nbtn t+%0d", name, i), 32'(sel ? nbtn_b : nbtn_a), 32'(e_nbtn));
            check($sformatf("%s busy t+%0d", name, i), 32'(sel ? busy_b : busy_a), 32'(e_busy));
            check($sformatf("%s done t+%0d", name, i), 32'(sel ? done_b : done_a), 32'(e_done));
            check($sformatf("%s sent t+%0d", name, i), 32'(sel ? sent_b : sent_a), 32'(sent));
            if (int'(i) == inj) begin
                set_start(sel, 1'b1);
                set_count(sel, 4'd5);
            end else if (nxt >= 0 && int'(i) == len) begin
                set_start(sel, 1'b1);
                set_count(sel, 4'(nxt));
            end else begin
                set_start(sel, 1'b0);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst nbtn", 32'(nbtn_a), 32'd1);
        check("rst busy", 32'(busy_a), 32'd0);
        check("rst done", 32'(done_a), 32'd0);
        check("rst sent", 32'(sent_a), 32'd0);
        check("rst nbtn_nb", 32'(nbtn_b), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle nbtn", 32'(nbtn_a), 32'd1);
        check("idle busy", 32'(busy_a), 32'd0);

        run_seq("press3", 1'b0, 3, 120, 0, -1, 1'b0);
        run_seq("count0", 1'b0, 0, 6, 0, -1, 1'b0);
        run_seq("ignore", 1'b0, 3, 120, 50, -1, 1'b0);

        // Second HOLD of a 3-press run spans offsets 51..58.
        run_seq("midrst", 1'b0, 3, 54, 0, -1, 1'b0);
        check("pre-rst sent", 32'(sent_a), 32'd1);
        rst = 1'b1;
        #1;
        check("async nbtn", 32'(nbtn_a), 32'd1);
        check("async busy", 32'(busy_a), 32'd0);
        check("async done", 32'(done_a), 32'd0);
        check("async sent", 32'(sent_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_seq("after", 1'b0, 2, 80, 0, -1, 1'b0);

        run_seq("press15", 1'b0, 15, 571, 0, 2, 1'b0);
        run_seq("b2b", 1'b0, 2, 80, 0, -1, 1'b1);

        run_seq("nobounce", 1'b1, 1, 20, 0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
